// File: rtl/rt_ibex_window_spill_ctrl.sv
// Register-window spill/fill sequencer: turns interrupt push / mret pop into window
// pointer moves, spilling the live window to a memory frame stack when hardware runs out.
module rt_ibex_window_spill_ctrl #(
    parameter int unsigned NumRegisterWindows = 4,
    parameter int unsigned WindowSize         = 7,
    parameter int unsigned MaxSpillFrames     = 8,
    parameter logic [31:0] SpillBase          = 32'h0000_1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  logic        pop_i,
    output logic        busy_o,
    output logic        increment_ptr_o,
    output logic        decrement_ptr_o,
    output logic [4:0]  rf_raddr_o,
    input  logic [31:0] rf_rdata_i,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        rf_we_o,
    input  logic [31:0] aux_mcause_i,
    input  logic [31:0] aux_mepc_i,
    output logic        csr_restore_o,
    output logic [31:0] csr_mcause_o,
    output logic [31:0] csr_mepc_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic        data_we_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic [1:0]  hw_depth_o,
    output logic [3:0]  spill_cnt_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PTR,
        S_SPILL_REQ,
        S_SPILL_RESP,
        S_FILL_REQ,
        S_FILL_RESP,
        S_RESTORE
    } state_e;

    localparam logic [1:0]  MaxDepth    = 2'(NumRegisterWindows - 1);
    localparam logic [3:0]  MaxFrames   = 4'(MaxSpillFrames);
    localparam logic [3:0]  NumRegWords = 4'(WindowSize);
    localparam logic [3:0]  LastWord    = 4'(WindowSize + 1);
    localparam logic [31:0] FrameBytes  = 32'(4 * (WindowSize + 2));

    state_e      state_q, state_d;
    logic [1:0]  hw_depth_q, hw_depth_d;
    logic [3:0]  spill_cnt_q, spill_cnt_d;
    logic [3:0]  word_q, word_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mepc_q, mepc_d;
    logic        busy_q, busy_d;
    logic        inc_q, inc_d;
    logic        dec_q, dec_d;
    logic        err_q, err_d;

    logic [3:0]  frame;
    logic [31:0] word_addr;

    // Word k of a frame holds x1, x5, x10, x11, x12, x13, x15, then mcause, mepc.
    function automatic logic [4:0] win_reg(input logic [3:0] w);
        case (w)
            4'd0:    return 5'd1;
            4'd1:    return 5'd5;
            4'd2:    return 5'd10;
            4'd3:    return 5'd11;
            4'd4:    return 5'd12;
            4'd5:    return 5'd13;
            default: return 5'd15;
        endcase
    endfunction

    // A fill reads back the topmost occupied frame; a spill writes the next free one.
    assign frame     = (state_q == S_FILL_REQ) ? spill_cnt_q - 4'd1 : spill_cnt_q;
    assign word_addr = SpillBase + {28'd0, frame} * FrameBytes + {26'd0, word_q, 2'b00};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        hw_depth_d    = hw_depth_q;
        spill_cnt_d   = spill_cnt_q;
        word_d        = word_q;
        mcause_d      = mcause_q;
        mepc_d        = mepc_q;
        inc_d         = 1'b0;
        dec_d         = 1'b0;
        err_d         = 1'b0;
        rf_raddr_o    = '0;
        rf_waddr_o    = '0;
        rf_wdata_o    = '0;
        rf_we_o       = 1'b0;
        csr_restore_o = 1'b0;
        data_req_o    = 1'b0;
        data_we_o     = 1'b0;
        data_addr_o   = '0;
        data_wdata_o  = '0;

        case (state_q)
            S_IDLE: begin
                if (push_i && pop_i) begin
                    err_d = 1'b1;
                end else if (push_i) begin
                    if (hw_depth_q < MaxDepth) begin
                        state_d = S_PTR;
                        inc_d   = 1'b1;
                    end else if (spill_cnt_q < MaxFrames) begin
                        state_d = S_SPILL_REQ;
                        word_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (pop_i) begin
                    if (spill_cnt_q != '0) begin
                        state_d = S_FILL_REQ;
                        word_d  = '0;
                    end else if (hw_depth_q != '0) begin
                        state_d = S_PTR;
                        dec_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_PTR: begin
                // The registered pulse still shows which way the pointer moved.
                hw_depth_d = inc_q ? hw_depth_q + 2'd1 : hw_depth_q - 2'd1;
                state_d    = S_IDLE;
            end

            S_SPILL_REQ: begin
                data_req_o  = 1'b1;
                data_we_o   = 1'b1;
                data_addr_o = word_addr;
                if (word_q < NumRegWords) begin
                    rf_raddr_o   = win_reg(word_q);
                    data_wdata_o = rf_rdata_i;
                end else if (word_q == NumRegWords) begin
                    data_wdata_o = aux_mcause_i;
                end else begin
                    data_wdata_o = aux_mepc_i;
                end
                if (data_gnt_i) state_d = S_SPILL_RESP;
            end

            S_SPILL_RESP: begin
                if (data_rvalid_i) begin
                    if (word_q == LastWord) begin
                        spill_cnt_d = spill_cnt_q + 4'd1;
                        state_d     = S_IDLE;
                    end else begin
                        word_d  = word_q + 4'd1;
                        state_d = S_SPILL_REQ;
                    end
                end
            end

            S_FILL_REQ: begin
                data_req_o  = 1'b1;
                data_addr_o = word_addr;
                if (data_gnt_i) state_d = S_FILL_RESP;
            end

            S_FILL_RESP: begin
                if (data_rvalid_i) begin
                    if (word_q < NumRegWords) begin
                        rf_we_o    = 1'b1;
                        rf_waddr_o = win_reg(word_q);
                        rf_wdata_o = data_rdata_i;
                    end else if (word_q == NumRegWords) begin
                        mcause_d = data_rdata_i;
                    end else begin
                        mepc_d = data_rdata_i;
                    end
                    if (word_q == LastWord) begin
                        state_d = S_RESTORE;
                    end else begin
                        word_d  = word_q + 4'd1;
                        state_d = S_FILL_REQ;
                    end
                end
            end

            S_RESTORE: begin
                csr_restore_o = 1'b1;
                spill_cnt_d   = spill_cnt_q - 4'd1;
                state_d       = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            hw_depth_q  <= '0;
            spill_cnt_q <= '0;
            word_q      <= '0;
            mcause_q    <= '0;
            mepc_q      <= '0;
            busy_q      <= 1'b0;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            state_q     <= state_d;
            hw_depth_q  <= hw_depth_d;
            spill_cnt_q <= spill_cnt_d;
            word_q      <= word_d;
            mcause_q    <= mcause_d;
            mepc_q      <= mepc_d;
            busy_q      <= busy_d;
            inc_q       <= inc_d;
            dec_q       <= dec_d;
            err_q       <= err_d;
        end
    end

    assign busy_o          = busy_q;
    assign increment_ptr_o = inc_q;
    assign decrement_ptr_o = dec_q;
    assign err_o           = err_q;
    assign csr_mcause_o    = mcause_q;
    assign csr_mepc_o      = mepc_q;
    assign hw_depth_o      = hw_depth_q;
    assign spill_cnt_o     = spill_cnt_q;

endmodule
